// File: rtl/panel_ctrl.sv
// Front-panel button conditioner: per-button synchronizer and debouncer, press
// detection, and a halt > run > cont arbiter issuing one-cycle command pulses.
module panel_ctrl #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_btn,
    input  logic       cont_btn,
    input  logic       halt_btn,
    output logic       run,
    output logic       cont,
    output logic       halt,
    output logic [2:0] btn_level
);

    localparam int RUN  = 0;
    localparam int CONT = 1;
    localparam int HALT = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [2:0]       raw;
    logic [2:0]       s1_q, s_q;
    logic [2:0]       lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       press;
    logic [2:0]       pend_q, pend_d;
    logic [2:0]       issue_q, issue_d;

    assign raw = {halt_btn, cont_btn, run_btn};

    // Debounce: the level flips only after DB_CYCLES consecutive mismatching edges.
    always_comb begin
        for (int b = 0; b < 3; b++) begin
            // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
            cnt_d[b] = '0;
            lvl_d[b] = lvl_q[b];
            if (s_q[b] != lvl_q[b]) begin
                if (cnt_q[b] == CNT_MAX) begin
                    lvl_d[b] = s_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign press = lvl_d & ~lvl_q;

    // Arbiter: a halt flushes everything, including presses landing on the same edge;
    // otherwise a press arriving on the clearing edge keeps its pending bit set.
    always_comb begin
        issue_d = '0;
        pend_d  = pend_q | press;
        if (pend_q[HALT]) begin
            issue_d[HALT] = 1'b1;
            pend_d        = press & 3'b100;
        end else if (pend_q[RUN]) begin
            issue_d[RUN] = 1'b1;
            pend_d       = (pend_q & ~3'b001) | press;
        end else if (pend_q[CONT]) begin
            issue_d[CONT] = 1'b1;
            pend_d        = (pend_q & ~3'b010) | press;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= '0;
            s_q     <= '0;
            lvl_q   <= '0;
            pend_q  <= '0;
            issue_q <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any register.
            for (int b = 0; b < 3; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_q    <= raw;
            s_q     <= s1_q;
            lvl_q   <= lvl_d;
            pend_q  <= pend_d;
            issue_q <= issue_d;
            for (int b = 0; b < 3; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    assign run       = issue_q[RUN];
    assign cont      = issue_q[CONT];
    assign halt      = issue_q[HALT];
    assign btn_level = lvl_q;

endmodule

// File: tb/tb_panel_ctrl.sv
// Bench for panel_ctrl: directed scenarios plus random button traffic, all
// checked every cycle against a sample-window reference model.
module tb_panel_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       run_btn, cont_btn, halt_btn;
    logic       run, cont, halt;
    logic [2:0] btn_level;

    int compared   = 0;
    int mismatched = 0;

    panel_ctrl #(.DB_CYCLES(D), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .run_btn   (run_btn),
        .cont_btn  (cont_btn),
        .halt_btn  (halt_btn),
        .run       (run),
        .cont      (cont),
        .halt      (halt),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    // Reference model: a button's level flips once its last D synchronized
    // samples all disagree with it; the sample window restarts after each flip.
    logic [2:0] m_s1, m_s, m_lvl, m_pend, m_out;
    bit         hist [3][$];

    function automatic void model_reset();
        m_s1 = '0; m_s = '0; m_lvl = '0; m_pend = '0; m_out = '0;
        for (int b = 0; b < 3; b++) hist[b].delete();
    endfunction

    function automatic void model_edge(input logic [2:0] raw);
        logic [2:0] new_lvl, press;
        bit         all_diff;
        new_lvl = m_lvl;
        for (int b = 0; b < 3; b++) begin
            hist[b].push_back(m_s[b]);
            if (hist[b].size() > D) void'(hist[b].pop_front());
            if (hist[b].size() == D) begin
                all_diff = 1'b1;
                for (int k = 0; k < D; k++) if (hist[b][k] == m_lvl[b]) all_diff = 1'b0;
                if (all_diff) begin
                    new_lvl[b] = ~m_lvl[b];
                    hist[b].delete();
                end
            end
        end
        press = new_lvl & ~m_lvl;
        m_out = '0;
        if (m_pend[2]) begin
            m_out[2] = 1'b1;
            m_pend   = {press[2], 2'b00};
        end else begin
            if (m_pend[0])      m_out[0] = 1'b1;
            else if (m_pend[1]) m_out[1] = 1'b1;
            m_pend = (m_pend & ~m_out) | press;
        end
        m_s   = m_s1;
        m_s1  = raw;
        m_lvl = new_lvl;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model, compare all outputs, return mid-cycle.
    task automatic step();
        logic [2:0] raw;
        raw = {halt_btn, cont_btn, run_btn};
        @(posedge clk);
        if (!reset) model_reset();
        else        model_edge(raw);
        #1;
        chk("run",       run,       m_out[0]);
        chk("cont",      cont,      m_out[1]);
        chk("halt",      halt,      m_out[2]);
        chk("btn_level", btn_level, m_lvl);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_lvl", btn_level, 3'b000);
        chk("rst_async_out", {halt, cont, run}, 3'b000);
    endtask

    task automatic idle(input int n);
        run_btn = 1'b0; cont_btn = 1'b0; halt_btn = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    int         n_run, n_cont, n_halt, n_both;
    logic [2:0] lvl_or;
    int         dur [3];

    initial begin
        model_reset();
        reset = 1'b0;
        run_btn = 1'b1; cont_btn = 1'b1; halt_btn = 1'b1;

        // Reset held with all buttons pressed
        for (int e = 1; e <= 3; e++) begin
            step();
            chk("rst_cmd", {halt, cont, run}, 3'b000);
            chk("rst_lvl", btn_level, 3'b000);
        end
        reset = 1'b1;
        idle(10);

        // Clean run press held for 12 cycles
        run_btn = 1'b1; n_run = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            n_run += int'(run);
            if (e == 5) chk("clean_lvl5", btn_level, 3'b000);
            if (e == 6) chk("clean_lvl6", btn_level, 3'b001);
            if (e == 7) chk("clean_run7", run, 1'b1);
            if (e == 8) chk("clean_run8", run, 1'b0);
        end
        chk("clean_once", n_run, 1);
        idle(10);

        // Bounce on cont: 2 high, 2 low, 2 high, then low
        n_cont = 0; lvl_or = '0;
        for (int e = 1; e <= 16; e++) begin
            cont_btn = (e <= 2 || (e >= 5 && e <= 6));
            step();
            n_cont += int'(cont);
            lvl_or |= btn_level;
        end
        chk("bounce_none", n_cont, 0);
        chk("bounce_lvl",  lvl_or, 3'b000);

        cont_btn = 1'b1; n_cont = 0;
        for (int e = 1; e <= 14; e++) begin
            if (e == 11) cont_btn = 1'b0;
            step();
            n_cont += int'(cont);
            if (e == 7) chk("bounce_cont7", cont, 1'b1);
        end
        chk("bounce_once", n_cont, 1);
        idle(10);

        // Simultaneous run and cont
        run_btn = 1'b1; cont_btn = 1'b1; n_both = 0;
        for (int e = 1; e <= 14; e++) begin
            step();
            n_both += int'(run && cont);
            if (e == 7) chk("sim_e7", {cont, run}, 2'b01);
            if (e == 8) chk("sim_e8", {cont, run}, 2'b10);
            if (e == 9) chk("sim_e9", {cont, run}, 2'b00);
        end
        chk("sim_excl", n_both, 0);
        idle(10);

        // Halt cancels a simultaneous run
        run_btn = 1'b1; halt_btn = 1'b1; n_run = 0; n_halt = 0;
        for (int e = 1; e <= 27; e++) begin
            step();
            n_run  += int'(run);
            n_halt += int'(halt);
            if (e == 7) chk("halt_e7", halt, 1'b1);
            if (e == 8) chk("halt_e8", halt, 1'b0);
        end
        chk("halt_norun", n_run,  0);
        chk("halt_once",  n_halt, 1);
        idle(12);

        // Reset during debounce, button still held afterwards
        run_btn = 1'b1; n_run = 0;
        for (int e = 1; e <= 3; e++) step();
        pulse_reset();
        for (int e = 1; e <= 12; e++) begin
            step();
            n_run += int'(run);
            if (e == 4) chk("rstmid_abs7", run, 1'b0);
            if (e == 7) chk("rstmid_run",  run, 1'b1);
        end
        chk("rstmid_once", n_run, 1);
        idle(12);

        // Random traffic: level runs of 1..10 cycles, occasional reset
        for (int b = 0; b < 3; b++) dur[b] = 1;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 3; b++) begin
                dur[b]--;
                if (dur[b] == 0) begin
                    dur[b] = int'($urandom_range(1, 10));
                    case (b)
                        0: run_btn  = ~run_btn;
                        1: cont_btn = ~cont_btn;
                        default: halt_btn = ~halt_btn;
                    endcase
                end
            end
            if ($urandom_range(0, 199) == 0) pulse_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/panel_ctrl.md
# panel_ctrl

Front-panel input conditioner for the tinycpu control path. Takes the three raw, asynchronous, bouncing panel buttons (run, continue, halt), synchronizes and debounces each one, and turns each debounced press into a single-cycle command pulse. The pulses drive the `run`, `cont` and `halt` inputs of the CPU control state machine, which sits directly downstream. Simultaneous presses are arbitrated so that at most one command pulse is asserted in any cycle.

## Interface
Parameters:
- `DB_CYCLES`, default 16: consecutive mismatching cycles required before a debounced level changes; legal range 1 to 2^CNT_W−1.
- `CNT_W`, default 5: width of each debounce counter.

Ports:
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run_btn`  in  1  raw run button, asynchronous, active-high.
- `cont_btn`  in  1  raw continue button, asynchronous, active-high.
- `halt_btn`  in  1  raw halt button, asynchronous, active-high.
- `run`  out  1  registered single-cycle run command pulse.
- `cont`  out  1  registered single-cycle continue command pulse.
- `halt`  out  1  registered single-cycle halt command pulse.
- `btn_level`  out  3  debounced button levels as {halt, cont, run}, registered.

## Operation
- **Per-button path, three identical instances.**
  - Two-flop synchronizer: raw input → `s1` → `s`.
  - Debounce counter `cnt[CNT_W-1:0]` and stable level `lvl`.
  - When `s == lvl`, `cnt` is cleared to 0.
  - When `s != lvl` and `cnt == DB_CYCLES-1`, `lvl <= s` and `cnt <= 0`.
  - Otherwise, when `s != lvl`, `cnt` increments.
  - `lvl` therefore changes only after `DB_CYCLES` consecutive edges with a mismatch. Any shorter mismatch leaves `lvl` unchanged.
- **Press detect.** A press is detected on the edge where `lvl` goes 0→1. On that same edge the button's pending bit is set. A `lvl` transition 1→0 (release) generates nothing.
- **Holding a button** produces exactly one pulse. A second pulse requires a debounced release followed by a debounced re-press.
- **Arbiter.** Pending bits are `p_halt`, `p_run`, `p_cont`; priority is halt > run > cont. Each edge:
  - If `p_halt` is set, assert `halt` and clear all three pending bits. A pending run or cont is cancelled.
  - Else if `p_run` is set, assert `run` and clear `p_run`.
  - Else if `p_cont` is set, assert `cont` and clear `p_cont`.
  - Command outputs are registered and are high for exactly one cycle per issue. They are mutually exclusive by construction.
- **Set/clear collisions.** A pending bit that is set on the same edge it would be cleared remains set. Set wins, except for a halt cancel, which also suppresses run/cont presses detected on that same edge.
- **Reset.** Asserting `reset` (low) immediately clears all synchronizer flops, counters, `lvl`, pending bits and outputs. All outputs reset to 0.
  - Reset mid-debounce discards all progress.
  - A button still held when reset is released is re-debounced from scratch and yields one pulse.

## Timing
- Raw rising input settles before edge 1.
  - `s` = 1 after edge 2.
  - Mismatch is counted on edges 3 … 2+DB_CYCLES.
  - `lvl` and the pending bit are set at edge 2+DB_CYCLES.
  - The command pulse is high from edge 3+DB_CYCLES to edge 4+DB_CYCLES (uncontested case).
- Press-to-pulse latency is 3+DB_CYCLES cycles. `btn_level` leads the pulse by one cycle.
- Each lower-priority pending command is delayed one extra cycle per higher-priority command issued ahead of it.
- A minimum raw pulse width of DB_CYCLES+1 cycles guarantees detection. A glitch of DB_CYCLES−1 cycles or fewer is never detected.
- Counter never wraps: it is cleared at DB_CYCLES−1 or on a match.

## Test plan
All scenarios use DB_CYCLES=4 and CNT_W=3, with inputs changed mid-cycle before edge 1.
- **Reset values.** Hold `reset`=0 for 3 cycles with all buttons at 1 → `run`/`cont`/`halt`=0 and `btn_level`=3'b000 throughout.
- **Clean press.** `run_btn`=1 for 12 cycles → `btn_level[0]`=1 at edge 6; `run` high edge 7–8 only; no further pulse while held.
- **Bounce rejection.**
  - `cont_btn` high for 2 cycles, low 2, high 2, low → no `cont` pulse; `btn_level` stays 0.
  - Then a 10-cycle press → exactly one `cont` pulse at edge 7.
- **Simultaneous run and cont.** Both pressed in the same cycle → `run` edge 7–8, `cont` edge 8–9, never both high together.
- **Halt cancels.** `run_btn` and `halt_btn` pressed in the same cycle → `halt` edge 7–8; no `run` pulse within 20 cycles while both are held.
- **Reset mid-debounce.**
  - `run_btn`=1 from cycle 0; pulse `reset`=0 during cycle 4 → no pulse at edge 7.
  - After reset release (`run_btn` still 1), exactly one `run` pulse at 3+DB_CYCLES cycles past the first edge after release.
